// File: rtl/field_fade_ctrl.sv
// Pixel-path brightness sequencer: palette index pass-through, RGB scaling by a
// global level, and a frame-synchronised fade-out / hold-black / fade-in sequence.
module field_fade_ctrl #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       start,
  input  logic [3:0] pix_index,
  input  logic       blank,
  output logic [3:0] pal_index,
  input  logic [3:0] pal_red,
  input  logic [3:0] pal_green,
  input  logic [3:0] pal_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       busy,
  output logic       black_pulse,
  output logic [3:0] level,
  output logic [1:0] state_dbg
);

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(HOLD_FRAMES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FADE_OUT = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_FADE_IN  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [3:0]     level_q, level_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic           busy_q, busy_d;
  logic           bp_q, bp_d;
  logic [3:0]     red_q, red_d;
  logic [3:0]     green_q, green_d;
  logic [3:0]     blue_q, blue_d;

  // (c * (level + 1)) >> 4; the 8-bit product never overflows (15 * 16 = 240).
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
    logic [7:0] prod;
    prod = {4'b0000, c} * ({4'b0000, l} + 8'd1);
    return prod[7:4];
  endfunction

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    bp_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FADE_OUT;
          fcnt_d  = '0;
        end
      end
      S_FADE_OUT: begin
        if (frame_start) begin
          if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) begin
              state_d = S_HOLD;
              hcnt_d  = '0;
              bp_d    = 1'b1;
            end
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        // The frame_start seen with the counter already at its last value ends the hold.
        if (frame_start) begin
          if (hcnt_q == HC_LAST) begin
            state_d = S_FADE_IN;
            fcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      S_FADE_IN: begin
        if (frame_start) begin
          if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            level_d = level_q + 4'd1;
            if (level_q == 4'd14) begin
              state_d = S_IDLE;
            end
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = 4'd15;
        fcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    red_d   = 4'd0;
    green_d = 4'd0;
    blue_d  = 4'd0;
    if (!blank) begin
      red_d   = scale(pal_red, level_q);
      green_d = scale(pal_green, level_q);
      blue_d  = scale(pal_blue, level_q);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      level_q <= 4'd15;
      fcnt_q  <= '0;
      hcnt_q  <= '0;
      busy_q  <= 1'b0;
      bp_q    <= 1'b0;
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      busy_q  <= busy_d;
      bp_q    <= bp_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign pal_index   = pix_index;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign busy        = busy_q;
  assign black_pulse = bp_q;
  assign level       = level_q;
  assign state_dbg   = state_q;

endmodule
